blood_entry_ctrl: RTL and testbench

//   Input-sequencing controller for the blood-type calculator datapath.
//   - Replaces raw switch-edge latching with synchronised, debounced parent entry.
//   - Entry is order-independent: father and mother can be entered in either order.
//   - Drives the parent codes, valid flags, calculator enable and a display enable
//     (blinks while waiting for the second parent) for the two-digit 7-seg path.

---
 rtl/blood_pkg.sv | 26 ++
 rtl/blood_entry_ctrl_debounce_edge.sv | 49 ++++
 rtl/blood_entry_ctrl.sv | 143 ++++++++++++++
 tb/tb_blood_entry_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/blood_pkg.sv
// Shared types and constants for the blood-type entry controller.
package blood_pkg;

    // Entry FSM states; encoding is visible on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_M = 2'd1,
        ST_WAIT_F = 2'd2,
        ST_SHOW   = 2'd3
    } state_t;

    // Bit positions of the alleles inside a parent code.
    localparam int unsigned A_BIT = 1;
    localparam int unsigned B_BIT = 0;

    // Board timing at 50 MHz.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;
    localparam int unsigned DEF_BLINK_CYCLES    = 12_500_000;
    localparam int unsigned DEF_TIMEOUT_CYCLES  = 500_000_000;

    // Counter width able to hold 0 .. n-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/blood_entry_ctrl_debounce_edge.sv
// Synchroniser, debouncer and rising-edge pulse for one asynchronous pin.
module debounce_edge
    import blood_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_rise
);

    localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES);

    logic          r_s1;
    logic          r_s2;
    logic          r_lvl;
    logic          r_rise;
    logic [CW-1:0] r_cnt;
    logic          w_done;

    assign w_done = (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign o_rise = r_rise;

    // Two-flop sync, then count consecutive samples that disagree with the accepted level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_lvl  <= 1'b0;
            r_rise <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_s1   <= i_pin;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            if (r_s2 == r_lvl) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_cnt  <= '0;
                r_lvl  <= r_s2;
                r_rise <= r_s2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/blood_entry_ctrl.sv
// Order-independent, debounced parent-code entry for the blood-type calculator.
module blood_entry_ctrl
    import blood_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned BLINK_CYCLES    = DEF_BLINK_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic       Sys_CLK,
    input  logic       Sys_RST,
    input  logic [1:0] Switch,
    input  logic [1:0] Key,
    input  logic       Clr,
    output logic [1:0] father,
    output logic [1:0] mother,
    output logic       father_vld,
    output logic       mother_vld,
    output logic       calc_en,
    output logic       disp_en,
    output logic [3:0] LED,
    output logic [1:0] state_o
);

    localparam int unsigned TO_W = cnt_w(TIMEOUT_CYCLES);
    localparam int unsigned BL_W = cnt_w(BLINK_CYCLES);

    logic [1:0]      r_key_s1;
    logic [1:0]      r_key_s2;
    state_t          r_state;
    logic [1:0]      r_father;
    logic [1:0]      r_mother;
    logic            r_father_vld;
    logic            r_mother_vld;
    logic            r_calc_en;
    logic            r_disp_en;
    logic [TO_W-1:0] r_to;
    logic [BL_W-1:0] r_bc;

    logic            w_rise_f;
    logic            w_rise_m;
    logic            w_rise_clr;
    logic [1:0]      w_key;
    logic            w_wait;
    logic            w_to_done;
    logic            w_blink_wrap;
    logic            w_go_idle;

    debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_f (
        .i_clk(Sys_CLK), .i_rst(Sys_RST), .i_pin(Switch[1]), .o_rise(w_rise_f)
    );
    debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_m (
        .i_clk(Sys_CLK), .i_rst(Sys_RST), .i_pin(Switch[0]), .o_rise(w_rise_m)
    );
    debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .i_clk(Sys_CLK), .i_rst(Sys_RST), .i_pin(Clr), .o_rise(w_rise_clr)
    );

    // Key is a level read only at a capture, so it is synchronised but not debounced.
    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            r_key_s1 <= 2'b00;
            r_key_s2 <= 2'b00;
        end else begin
            r_key_s1 <= Key;
            r_key_s2 <= r_key_s1;
        end
    end

    assign w_key        = {r_key_s2[A_BIT], r_key_s2[B_BIT]};
    assign w_wait       = (r_state == ST_WAIT_M) || (r_state == ST_WAIT_F);
    assign w_to_done    = (r_to == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_blink_wrap = (r_bc == BL_W'(BLINK_CYCLES - 1));
    // Clear wins over switches; a switch rise beats an expiring timeout.
    assign w_go_idle    = w_rise_clr | (w_wait & w_to_done & ~w_rise_f & ~w_rise_m);

    // Entry FSM with capture registers, timeout and blink counters.
    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST || w_go_idle) begin
            r_state      <= ST_IDLE;
            r_father     <= 2'b00;
            r_mother     <= 2'b00;
            r_father_vld <= 1'b0;
            r_mother_vld <= 1'b0;
            r_calc_en    <= 1'b0;
            r_disp_en    <= 1'b0;
            r_to         <= '0;
            r_bc         <= '0;
        end else begin
            if (w_rise_f) begin
                r_father     <= w_key;
                r_father_vld <= 1'b1;
            end
            if (w_rise_m) begin
                r_mother     <= w_key;
                r_mother_vld <= 1'b1;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (w_rise_f || w_rise_m) begin
                        r_state   <= (w_rise_f && w_rise_m) ? ST_SHOW
                                   : (w_rise_f ? ST_WAIT_M : ST_WAIT_F);
                        r_calc_en <= w_rise_f && w_rise_m;
                        r_disp_en <= 1'b1;
                        r_to      <= '0;
                        r_bc      <= '0;
                    end
                end
                ST_WAIT_M, ST_WAIT_F: begin
                    if ((r_state == ST_WAIT_M) ? w_rise_m : w_rise_f) begin
                        r_state   <= ST_SHOW;
                        r_calc_en <= 1'b1;
                        r_disp_en <= 1'b1;
                        r_to      <= '0;
                        r_bc      <= '0;
                    end else begin
                        // Recapturing the already-entered parent restarts the timeout.
                        r_to <= (w_rise_f || w_rise_m) ? '0 : r_to + TO_W'(1);
                        if (w_blink_wrap) begin
                            r_bc      <= '0;
                            r_disp_en <= ~r_disp_en;
                        end else begin
                            r_bc <= r_bc + BL_W'(1);
                        end
                    end
                end
                ST_SHOW: begin
                    r_disp_en <= 1'b1;
                    r_calc_en <= 1'b1;
                end
            endcase
        end
    end

    assign father     = r_father;
    assign mother     = r_mother;
    assign father_vld = r_father_vld;
    assign mother_vld = r_mother_vld;
    assign calc_en    = r_calc_en;
    assign disp_en    = r_disp_en;
    assign LED        = {r_father, r_mother};
    assign state_o    = r_state;

endmodule

// File: tb/tb_blood_entry_ctrl.sv
// Directed bench for blood_entry_ctrl with short debounce, blink and timeout periods.
module tb_blood_entry_ctrl;

    logic       Sys_CLK;
    logic       Sys_RST;
    logic [1:0] Switch;
    logic [1:0] Key;
    logic       Clr;
    logic [1:0] father;
    logic [1:0] mother;
    logic       father_vld;
    logic       mother_vld;
    logic       calc_en;
    logic       disp_en;
    logic [3:0] LED;
    logic [1:0] state_o;

    int total = 0;
    int bad   = 0;

    blood_entry_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .BLINK_CYCLES   (8),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .Sys_CLK   (Sys_CLK),
        .Sys_RST   (Sys_RST),
        .Switch    (Switch),
        .Key       (Key),
        .Clr       (Clr),
        .father    (father),
        .mother    (mother),
        .father_vld(father_vld),
        .mother_vld(mother_vld),
        .calc_en   (calc_en),
        .disp_en   (disp_en),
        .LED       (LED),
        .state_o   (state_o)
    );

    initial Sys_CLK = 1'b0;
    always #5 Sys_CLK = ~Sys_CLK;

    // Advance n clock edges; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge Sys_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] st, input logic [1:0] f,
                           input logic [1:0] m, input logic fv, input logic mv,
                           input logic ce, input logic de);
        chk({tag, ".state"},  32'(state_o),    32'(st));
        chk({tag, ".father"}, 32'(father),     32'(f));
        chk({tag, ".mother"}, 32'(mother),     32'(m));
        chk({tag, ".fvld"},   32'(father_vld), 32'(fv));
        chk({tag, ".mvld"},   32'(mother_vld), 32'(mv));
        chk({tag, ".calc"},   32'(calc_en),    32'(ce));
        chk({tag, ".disp"},   32'(disp_en),    32'(de));
        chk({tag, ".led"},    32'(LED),        32'({f, m}));
    endtask

    initial begin
        // Reset with all pins low, then a long quiet period.
        Sys_RST = 1'b1; Switch = 2'b00; Key = 2'b00; Clr = 1'b0;
        tick(3);
        Sys_RST = 1'b0;
        chk_out("rst", 2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(100);
        chk_out("quiet", 2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Father then mother; capture lands 7 cycles after the pin.
        Key = 2'b10; Switch = 2'b10;
        tick(6);
        chk("f_early.state", 32'(state_o), 32'd0);
        chk("f_early.fvld", 32'(father_vld), 32'd0);
        tick(1);
        chk_out("f_cap", 2'd1, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(3);
        Key = 2'b01; Switch = 2'b01;
        tick(6);
        chk("m_early.state", 32'(state_o), 32'd1);
        tick(1);
        chk_out("m_cap", 2'd3, 2'b10, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1);
        Switch = 2'b00;
        tick(10);

        // Clear back to idle.
        Clr = 1'b1;
        tick(7);
        chk_out("clr1", 2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        Clr = 1'b0;
        tick(10);

        // Chatter on the father switch never settles long enough.
        Key = 2'b11;
        for (int i = 0; i < 10; i++) begin
            Switch = 2'b10; tick(1);
            Switch = 2'b00; tick(3);
        end
        tick(20);
        chk_out("chatter", 2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Father only: blink every 8 cycles, then timeout after 64 cycles in WAIT_M.
        Key = 2'b10; Switch = 2'b10;
        tick(7);
        Switch = 2'b00;
        chk_out("to_enter", 2'd1, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(7);  chk("blink7",  32'(disp_en), 32'd1);
        tick(1);  chk("blink8",  32'(disp_en), 32'd0);
        tick(7);  chk("blink15", 32'(disp_en), 32'd0);
        tick(1);  chk("blink16", 32'(disp_en), 32'd1);
        tick(47);
        chk_out("to_last", 2'd1, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_out("to_fire", 2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Both to SHOW, live recapture of mother, then Clr beating a father rise.
        Key = 2'b10; Switch = 2'b11;
        tick(7);
        chk_out("show_a", 2'd3, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1);
        Switch = 2'b00;
        tick(10);
        Key = 2'b01; Switch = 2'b01;
        tick(7);
        chk_out("show_live", 2'd3, 2'b10, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1);
        Switch = 2'b00;
        tick(10);
        Switch = 2'b10; Clr = 1'b1;
        tick(7);
        chk_out("clr_prio", 2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(5);
        Switch = 2'b00; Clr = 1'b0;
        tick(10);
        chk_out("clr_hold", 2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Both switches together from IDLE with Key=11.
        Key = 2'b11; Switch = 2'b11;
        tick(6);
        chk("both_early.state", 32'(state_o), 32'd0);
        tick(1);
        chk_out("both", 2'd3, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
        Switch = 2'b00;
        tick(10);
        Clr = 1'b1;
        tick(7);
        chk("clr2.state", 32'(state_o), 32'd0);
        Clr = 1'b0;
        tick(10);

        // Reset in the middle of WAIT_M with the father switch still held.
        Switch = 2'b10;
        tick(7);
        chk_out("rw_wait", 2'd1, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(5);
        Sys_RST = 1'b1;
        tick(1);
        chk_out("rw_rst", 2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        Sys_RST = 1'b0;
        tick(6);
        chk("rw_early.state", 32'(state_o), 32'd0);
        tick(1);
        chk_out("rw_recap", 2'd1, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        Switch = 2'b00;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
